// File: rtl/sr_input_conditioner.sv
// Turns two raw, bouncing set/reset inputs into clean one-cycle S/R pulses for an
// SR latch, arbitrating S/R conflicts and keeping a registered shadow of Q.
module sr_input_conditioner #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S_raw,
  input  logic R_raw,
  output logic S,
  output logic R,
  output logic Q,
  output logic Qn,
  output logic illegal
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD_LOW,
    HOLD_HIGH,
    CONFLICT
  } state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0]       raw_v;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [CNT_W-1:0] cnt [2];

  state_t state;
  logic   s_rise;
  logic   r_rise;

  assign raw_v = {R_raw, S_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      sync1 <= raw_v;
      sync2 <= sync1;
      db_d  <= db;
      // A change is accepted only on its DB_CYCLES-th consecutive mismatched cycle.
      for (int unsigned ch = 0; ch < 2; ch++) begin
        if (sync2[ch] == db[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == CNT_LAST) begin
          db[ch]  <= sync2[ch];
          cnt[ch] <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + CNT_W'(1);
        end
      end
    end
  end

  assign s_rise = db[0] & ~db_d[0];
  assign r_rise = db[1] & ~db_d[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD_LOW;
      S       <= 1'b0;
      R       <= 1'b0;
      Q       <= 1'b0;
      illegal <= 1'b0;
    end else begin
      S <= 1'b0;
      R <= 1'b0;
      case (state)
        HOLD_LOW, HOLD_HIGH: begin
          if (db[0] && db[1]) begin
            state   <= CONFLICT;
            illegal <= 1'b1;
          end else if (s_rise) begin
            S     <= 1'b1;
            Q     <= 1'b1;
            state <= HOLD_HIGH;
          end else if (r_rise) begin
            R     <= 1'b1;
            Q     <= 1'b0;
            state <= HOLD_LOW;
          end
        end
        CONFLICT: begin
          // Q was frozen on entry; leaving returns to the hold state it implies.
          if (!db[0] && !db[1]) begin
            illegal <= 1'b0;
            state   <= Q ? HOLD_HIGH : HOLD_LOW;
          end
        end
        default: begin
          state   <= HOLD_LOW;
          illegal <= 1'b0;
        end
      endcase
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: directed scenarios plus random bouncing inputs,
// all compared each cycle against a queue-based behavioural model.
module tb_sr_input_conditioner;

  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic S_raw, R_raw;
  logic S, R, Q, Qn, illegal;

  int checks   = 0;
  int failures = 0;

  sr_input_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .S_raw(S_raw), .R_raw(R_raw),
    .S(S), .R(R), .Q(Q), .Qn(Qn), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Model: raw samples delayed two edges feed a window of synced history; a
  // debounced level flips once DB consecutive synced samples disagree with it.
  logic rawq_s[$], rawq_r[$], hs[$], hr[$];
  logic m_sdb, m_rdb, m_sdb_d, m_rdb_d;
  logic m_q, m_conf, m_S, m_R;

  function automatic int mismatch_run(input logic h[$], input logic level);
    int n = 0;
    for (int i = h.size() - 1; i >= 0; i--) begin
      if (h[i] == level) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    rawq_s.delete(); rawq_r.delete(); hs.delete(); hr.delete();
    m_sdb = 0; m_rdb = 0; m_sdb_d = 0; m_rdb_d = 0;
    m_q = 0; m_conf = 0; m_S = 0; m_R = 0;
  endtask

  task automatic model_edge(input logic s_in, input logic r_in);
    logic ss, rs, nsdb, nrdb, srise, rrise;
    ss = (rawq_s.size() == 2) ? rawq_s[0] : 1'b0;
    rs = (rawq_r.size() == 2) ? rawq_r[0] : 1'b0;
    rawq_s.push_back(s_in); if (rawq_s.size() > 2) void'(rawq_s.pop_front());
    rawq_r.push_back(r_in); if (rawq_r.size() > 2) void'(rawq_r.pop_front());
    hs.push_back(ss); if (hs.size() > DB) void'(hs.pop_front());
    hr.push_back(rs); if (hr.size() > DB) void'(hr.pop_front());
    nsdb = (mismatch_run(hs, m_sdb) >= DB) ? ~m_sdb : m_sdb;
    nrdb = (mismatch_run(hr, m_rdb) >= DB) ? ~m_rdb : m_rdb;
    srise = m_sdb && !m_sdb_d;
    rrise = m_rdb && !m_rdb_d;
    m_S = 0; m_R = 0;
    if (m_conf) begin
      if (!m_sdb && !m_rdb) m_conf = 0;
    end else if (m_sdb && m_rdb) begin
      m_conf = 1;
    end else if (srise) begin
      m_S = 1; m_q = 1;
    end else if (rrise) begin
      m_R = 1; m_q = 0;
    end
    m_sdb_d = m_sdb; m_rdb_d = m_rdb;
    m_sdb = nsdb;    m_rdb = nrdb;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("S", S, m_S);
    chk("R", R, m_R);
    chk("Q", Q, m_q);
    chk("Qn", Qn, ~m_q);
    chk("illegal", illegal, m_conf);
    chk("no_S_and_R", S & R, 1'b0);
  endtask

  // Called at a negedge: drive inputs, take one rising edge, check at the next negedge.
  task automatic tick(input logic s_in, input logic r_in);
    S_raw = s_in; R_raw = r_in;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(s_in, r_in);
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input logic s_in, input logic r_in, input int n,
                     output int first_s, output int first_r,
                     output int n_s, output int n_r);
    first_s = -1; first_r = -1; n_s = 0; n_r = 0;
    for (int i = 1; i <= n; i++) begin
      tick(s_in, r_in);
      if (S) begin n_s++; if (first_s < 0) first_s = i; end
      if (R) begin n_r++; if (first_r < 0) first_r = i; end
    end
  endtask

  initial begin
    int fs, fr, ns, nr, len;
    logic rs_in, rr_in;
    rst_n = 0; S_raw = 0; R_raw = 0;
    model_reset();
    @(negedge clk);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("reset_Qn", Qn, 1'b1);
    chk("reset_illegal", illegal, 1'b0);
    rst_n = 1;
    run(0, 0, 4, fs, fr, ns, nr);

    // Clean set: pulse on edge DB+3, exactly one cycle.
    run(1, 0, 15, fs, fr, ns, nr);
    chk_int("set_latency", fs, DB + 3);
    chk_int("set_pulse_count", ns, 1);
    chk_int("set_no_R", nr, 0);
    chk("set_Q", Q, 1'b1);
    chk("set_Qn", Qn, 1'b0);
    run(0, 0, 12, fs, fr, ns, nr);
    chk_int("release_no_pulse", ns + nr, 0);

    // Bounce: 3-cycle burst rejected, final rise accepted 7 edges later.
    run(1, 0, 3, fs, fr, ns, nr);
    chk_int("burst_no_pulse", ns, 0);
    run(0, 0, 1, fs, fr, ns, nr);
    chk_int("gap_no_pulse", ns, 0);
    run(1, 0, 15, fs, fr, ns, nr);
    chk_int("bounce_latency", fs, DB + 3);
    chk_int("bounce_pulse_count", ns, 1);

    // Asynchronous reset mid-cycle with S_raw held and Q=1.
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_S", S, 1'b0);
    chk("async_R", R, 1'b0);
    chk("async_Q", Q, 1'b0);
    chk("async_Qn", Qn, 1'b1);
    chk("async_illegal", illegal, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run(1, 0, 15, fs, fr, ns, nr);
    chk_int("post_reset_latency", fs, DB + 3);
    chk_int("post_reset_count", ns, 1);
    run(0, 0, 12, fs, fr, ns, nr);

    // Reset after set.
    run(0, 1, 15, fs, fr, ns, nr);
    chk_int("reset_latency", fr, DB + 3);
    chk_int("reset_pulse_count", nr, 1);
    chk_int("reset_no_S", ns, 0);
    chk("reset_Q", Q, 1'b0);
    chk("reset_Qn2", Qn, 1'b1);
    run(0, 0, 12, fs, fr, ns, nr);

    // Conflict from Q=0, then release both.
    run(1, 1, 15, fs, fr, ns, nr);
    chk_int("conflict_no_pulse", ns + nr, 0);
    chk("conflict_illegal", illegal, 1'b1);
    chk("conflict_Q", Q, 1'b0);
    run(0, 0, 15, fs, fr, ns, nr);
    chk_int("conflict_exit_no_pulse", ns + nr, 0);
    chk("conflict_exit_illegal", illegal, 1'b0);
    chk("conflict_exit_Q", Q, 1'b0);

    // Partial exit: release R only, then S, then a fresh press.
    run(1, 1, 15, fs, fr, ns, nr);
    chk("partial_illegal_in", illegal, 1'b1);
    run(1, 0, 15, fs, fr, ns, nr);
    chk_int("partial_no_S", ns, 0);
    chk("partial_still_illegal", illegal, 1'b1);
    run(0, 0, 12, fs, fr, ns, nr);
    chk("partial_exit_illegal", illegal, 1'b0);
    run(1, 0, 15, fs, fr, ns, nr);
    chk_int("partial_new_press", fs, DB + 3);
    chk("partial_new_Q", Q, 1'b1);

    // Random bouncing segments; per-cycle checks come from the model.
    for (int seg = 0; seg < 80; seg++) begin
      rs_in = 1'($urandom_range(0, 1));
      rr_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * DB + 3);
      run(rs_in, rr_in, len, fs, fr, ns, nr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_input_conditioner.md
Name: sr_input_conditioner

Overview:
Conditions two raw asynchronous set/reset inputs (push-buttons or switches) into clean, single-cycle S/R command pulses for the downstream SR latch. It synchronises and debounces each input and arbitrates set/reset conflicts so the latch never receives S=R=1. It also keeps a registered shadow of the latch state (Q/Qn) for the rest of the design.

Parameters:
DB_CYCLES, 4, consecutive synchronised cycles an input must differ from its debounced value before the change is accepted (legal range 2..255).
CNT_W, 8, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
S_raw  input  1  raw set request, asynchronous, may bounce.
R_raw  input  1  raw reset request, asynchronous, may bounce.
S  output  1  set pulse to latch, one cycle wide.
R  output  1  reset pulse to latch, one cycle wide.
Q  output  1  registered shadow of latch state.
Qn  output  1  always ~Q.
illegal  output  1  high while in CONFLICT state.

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, counters and debounced levels = 0; S=0, R=0, Q=0, Qn=1, illegal=0; state = HOLD_LOW. Reset mid-debounce or mid-conflict abandons all progress. No output pulse on reset release.
- Synchroniser: 2-flop chain per input (s_sync, r_sync). All downstream logic uses only synced values.
- Debounce, per channel, independently: if sync != db, cnt increments; when cnt == DB_CYCLES-1 and still mismatched, db <= sync and cnt <= 0. If sync == db, cnt <= 0. A glitch shorter than DB_CYCLES cycles is never accepted.
- Edge detect: s_rise = s_db & ~s_db_d; r_rise likewise (db delayed one cycle).
- FSM states: HOLD_LOW (Q=0), HOLD_HIGH (Q=1), CONFLICT.
  - HOLD_*: s_rise & ~r_db -> pulse S, go HOLD_HIGH. r_rise & ~s_db -> pulse R, go HOLD_LOW. s_db & r_db (including simultaneous rises) -> CONFLICT, no pulse.
  - A set in HOLD_HIGH or a reset in HOLD_LOW still emits its pulse; Q is unchanged.
  - CONFLICT: illegal=1, S=R=0, Q holds its pre-conflict value. Exits only when s_db=0 and r_db=0, returning to HOLD_LOW or HOLD_HIGH per the held Q. No pulse on exit. If one input is released and the other stays held, there is no new rising edge, so no pulse.
- Outputs: S, R, Q and illegal are registered. Q changes on the same edge the S/R pulse asserts. S and R are never high together. A pulse is exactly 1 cycle.
- Latency: with the raw input rising just after edge 0 and held stable, the S/R pulse is high in the cycle after edge DB_CYCLES+3. The same holds for release detection into db.
- Counter never wraps: it is bounded by DB_CYCLES-1.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with S_raw=1 held -> S=R=0, Q=0, Qn=1, illegal=0 immediately; after release, set pulse follows at DB_CYCLES+3 edges.
- Clean set (DB_CYCLES=4): S_raw 0->1 after edge 0, held -> S=1 only in the cycle after edge 7; Q=1, Qn=0 from edge 7; R stays 0.
- Bounce: S_raw high for 3 cycles, low 1, then high and held -> exactly one S pulse, 7 edges after the final rise; no pulse from the 3-cycle burst.
- Reset after set: from Q=1, R_raw held -> single R pulse, Q=0, Qn=1.
- Illegal: S_raw and R_raw both held from Q=0 -> illegal=1, S=R=0, Q stays 0; release both -> illegal=0 after debounce, state HOLD_LOW, no pulse.
- Partial conflict exit: in CONFLICT, release R_raw only -> no S pulse, illegal stays 1 until S_raw also released; new S_raw press then yields a normal S pulse.
